// File: rtl/gfx_pkg.sv
// gfx_pkg: types and default widths shared by the graphics pipeline blocks
// (line rasteriser, framebuffer writer).
//   line_state_t  - rasteriser FSM states
//   DEF_X_W       - default x coordinate width
//   DEF_Y_W       - default y coordinate width
//   DEF_COLOR_W   - default colour word width
package gfx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } line_state_t;

    localparam int DEF_X_W     = 8;
    localparam int DEF_Y_W     = 7;
    localparam int DEF_COLOR_W = 3;

endpackage

// File: rtl/draw_line_bres_if.sv
// draw_line_bres_if: command and pixel-stream bundle of the line rasteriser.
//   cmd_*   - line command, valid/ready (master -> slave)
//   px_*    - pixel stream, valid/ready (slave -> master)
//   busy    - rasteriser is working on a line
// master modport: command source / pixel sink side.
// slave modport:  the rasteriser.
interface draw_line_bres_if
    import gfx_pkg::*;
#(
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int COLOR_W = DEF_COLOR_W
) ();

    logic               cmd_valid;
    logic               cmd_ready;
    logic [X_W-1:0]     cmd_x0;
    logic [X_W-1:0]     cmd_x1;
    logic [Y_W-1:0]     cmd_y0;
    logic [Y_W-1:0]     cmd_y1;
    logic [COLOR_W-1:0] cmd_color;

    logic               px_valid;
    logic               px_ready;
    logic [X_W-1:0]     px_x;
    logic [Y_W-1:0]     px_y;
    logic [COLOR_W-1:0] px_color;
    logic               px_last;

    logic               busy;

    modport master (
        output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, px_ready,
        input  cmd_ready, px_valid, px_x, px_y, px_color, px_last, busy
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, px_ready,
        output cmd_ready, px_valid, px_x, px_y, px_color, px_last, busy
    );

endinterface

// File: rtl/draw_line_bres.sv
// draw_line_bres: Bresenham line rasteriser, all octants, one pixel per cycle
// with valid/ready backpressure on the pixel stream.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - draw_line_bres_if.slave: cmd_* command in, px_* pixels out, busy
module draw_line_bres
    import gfx_pkg::*;
#(
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int COLOR_W = DEF_COLOR_W
) (
    input  logic            clk,
    input  logic            rst,
    draw_line_bres_if.slave bus
);

    localparam int W = (X_W > Y_W) ? X_W : Y_W;

    line_state_t state, state_nxt;

    logic [X_W-1:0]     x0, x1, cx;
    logic [Y_W-1:0]     y0, y1, cy;
    logic [COLOR_W-1:0] color;
    logic [W-1:0]       dx, dy;
    logic [W-1:0]       setup_dx, setup_dy;
    logic               sx, sy;
    logic signed [W+1:0] err, err_nxt;
    logic signed [W+2:0] e2, dx_ext, dy_ext;
    logic               step_x, step_y, at_end, cmd_fire, px_fire;

    assign setup_dx = (x1 >= x0) ? W'(x1 - x0) : W'(x0 - x1);
    assign setup_dy = (y1 >= y0) ? W'(y1 - y0) : W'(y0 - y1);

    assign e2     = {err, 1'b0};
    assign dx_ext = {3'b000, dx};
    assign dy_ext = {3'b000, dy};
    // Both step decisions come from the same e2 so diagonal moves are atomic.
    assign step_x = (e2 >= -dy_ext);
    assign step_y = (e2 <= dx_ext);

    always_comb begin
        err_nxt = err;
        if (step_x) err_nxt = err_nxt - $signed({2'b00, dy});
        if (step_y) err_nxt = err_nxt + $signed({2'b00, dx});
    end

    assign at_end   = (cx == x1) && (cy == y1);
    assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
    assign px_fire  = bus.px_valid && bus.px_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.px_valid  = 1'b0;
        bus.px_last   = 1'b0;
        bus.busy      = 1'b0;
        unique case (state)
            IDLE: begin
                // Held low during reset so nothing is accepted on the reset edge.
                bus.cmd_ready = !rst;
                if (cmd_fire) state_nxt = SETUP;
            end
            SETUP: begin
                bus.busy  = 1'b1;
                state_nxt = DRAW;
            end
            DRAW: begin
                bus.busy     = 1'b1;
                bus.px_valid = 1'b1;
                bus.px_last  = at_end;
                if (px_fire && at_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x0    <= '0;
            x1    <= '0;
            y0    <= '0;
            y1    <= '0;
            color <= '0;
            dx    <= '0;
            dy    <= '0;
            sx    <= 1'b0;
            sy    <= 1'b0;
            err   <= '0;
            cx    <= '0;
            cy    <= '0;
        end else begin
            if (cmd_fire) begin
                x0    <= bus.cmd_x0;
                x1    <= bus.cmd_x1;
                y0    <= bus.cmd_y0;
                y1    <= bus.cmd_y1;
                color <= bus.cmd_color;
            end
            if (state == SETUP) begin
                dx  <= setup_dx;
                dy  <= setup_dy;
                sx  <= (x1 < x0);
                sy  <= (y1 < y0);
                err <= $signed({2'b00, setup_dx}) - $signed({2'b00, setup_dy});
                cx  <= x0;
                cy  <= y0;
            end
            if (state == DRAW && px_fire && !at_end) begin
                err <= err_nxt;
                if (step_x) cx <= sx ? cx - X_W'(1) : cx + X_W'(1);
                if (step_y) cy <= sy ? cy - Y_W'(1) : cy + Y_W'(1);
            end
        end
    end

    assign bus.px_x     = cx;
    assign bus.px_y     = cy;
    assign bus.px_color = color;

endmodule

// File: tb/tb_draw_line_bres.sv
module tb_draw_line_bres;
    import gfx_pkg::*;

    typedef struct {
        int x;
        int y;
        int c;
        bit last;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    draw_line_bres_if #(.X_W(DEF_X_W), .Y_W(DEF_Y_W), .COLOR_W(DEF_COLOR_W)) bus ();

    draw_line_bres #(.X_W(DEF_X_W), .Y_W(DEF_Y_W), .COLOR_W(DEF_COLOR_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   checks = 0;
    int   errors = 0;
    pix_t sb[$];
    int   exp_count[$];
    pix_t seen[$];
    int   line_pix = 0;
    bit   rand_ready = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: textbook all-octant Bresenham on plain integers.
    function automatic void ref_line(input int x0, input int y0, input int x1, input int y1,
                                     input int c, output pix_t q[$]);
        int ddx, ddy, stx, sty, e, ee, x, y;
        pix_t p;
        q.delete();
        ddx = (x1 > x0) ? x1 - x0 : x0 - x1;
        ddy = -((y1 > y0) ? y1 - y0 : y0 - y1);
        stx = (x0 < x1) ? 1 : -1;
        sty = (y0 < y1) ? 1 : -1;
        e = ddx + ddy;
        x = x0;
        y = y0;
        for (int n = 0; n < 1000; n++) begin
            p.x = x; p.y = y; p.c = c; p.last = (x == x1) && (y == y1);
            q.push_back(p);
            if (p.last) break;
            ee = 2 * e;
            if (ee >= ddy) begin e += ddy; x += stx; end
            if (ee <= ddx) begin e += ddx; y += sty; end
        end
    endfunction

    // Pixel-ready driver
    initial begin
        bus.px_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.px_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard
    initial begin
        bit   prev_stall = 1'b0;
        bit   prev_last  = 1'b0;
        pix_t held, got, exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                prev_last  = 1'b0;
                line_pix   = 0;
                continue;
            end
            if (prev_last) begin
                chk("idle_after_last_px_valid", bus.px_valid, 0);
                chk("idle_after_last_cmd_ready", bus.cmd_ready, 1);
            end
            if (prev_stall) begin
                chk("stall_px_valid", bus.px_valid, 1);
                chk("stall_px_x", bus.px_x, held.x);
                chk("stall_px_y", bus.px_y, held.y);
                chk("stall_px_color", bus.px_color, held.c);
                chk("stall_px_last", bus.px_last, held.last);
            end
            prev_last = 1'b0;
            got.x = int'(bus.px_x);
            got.y = int'(bus.px_y);
            got.c = int'(bus.px_color);
            got.last = bus.px_last;
            if (bus.px_valid && bus.px_ready) begin
                seen.push_back(got);
                line_pix++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel actual=(%0d,%0d) expected=none", got.x, got.y);
                end else begin
                    exp = sb.pop_front();
                    chk("px_x", got.x, exp.x);
                    chk("px_y", got.y, exp.y);
                    chk("px_color", got.c, exp.c);
                    chk("px_last", got.last, exp.last);
                end
                if (got.last) begin
                    if (exp_count.size() != 0) chk("pixel_count", line_pix, exp_count.pop_front());
                    line_pix  = 0;
                    prev_last = 1'b1;
                end
            end
            prev_stall = bus.px_valid && !bus.px_ready;
            held = got;
        end
    end

    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                            input int c, input bit check_lat);
        pix_t q[$];
        int   n = 0;
        int   ax, ay;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_x0 = 8'(x0);
        bus.cmd_y0 = 7'(y0);
        bus.cmd_x1 = 8'(x1);
        bus.cmd_y1 = 7'(y1);
        bus.cmd_color = 3'(c);
        while (!bus.cmd_ready && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) begin
            chk("cmd_ready_timeout", 0, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        ref_line(x0, y0, x1, y1, c, q);
        foreach (q[i]) sb.push_back(q[i]);
        ax = (x1 > x0) ? x1 - x0 : x0 - x1;
        ay = (y1 > y0) ? y1 - y0 : y0 - y1;
        exp_count.push_back(((ax > ay) ? ax : ay) + 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        if (check_lat) begin
            @(negedge clk);
            chk("lat_setup_px_valid", bus.px_valid, 0);
            chk("lat_setup_busy", bus.busy, 1);
            @(negedge clk);
            chk("lat_first_px_valid", bus.px_valid, 1);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || bus.px_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("line_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0 = '0;
        bus.cmd_x1 = '0;
        bus.cmd_y0 = '0;
        bus.cmd_y1 = '0;
        bus.cmd_color = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_px_valid", bus.px_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_px_x", bus.px_x, 0);
        chk("rst_px_y", bus.px_y, 0);
        chk("rst_px_color", bus.px_color, 0);
        chk("rst_px_last", bus.px_last, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);

        // Horizontal line with latency check
        seen.delete();
        send_cmd(10, 5, 14, 5, 3, 1'b1);
        wait_done();
        chk("horiz_count", seen.size(), 5);
        foreach (seen[i]) begin
            chk("horiz_x", seen[i].x, 10 + i);
            chk("horiz_y", seen[i].y, 5);
        end

        // Shallow line and its reverse
        seen.delete();
        send_cmd(0, 0, 3, 1, 5, 1'b0);
        wait_done();
        chk("shallow_count", seen.size(), 4);
        if (seen.size() == 4) begin
            chk("shallow_p1_x", seen[1].x, 1); chk("shallow_p1_y", seen[1].y, 0);
            chk("shallow_p2_x", seen[2].x, 2); chk("shallow_p2_y", seen[2].y, 1);
            chk("shallow_p3_x", seen[3].x, 3); chk("shallow_p3_y", seen[3].y, 1);
        end
        seen.delete();
        send_cmd(3, 1, 0, 0, 6, 1'b0);
        wait_done();
        chk("rev_count", seen.size(), 4);
        if (seen.size() == 4) begin
            chk("rev_p0_x", seen[0].x, 3); chk("rev_p0_y", seen[0].y, 1);
            chk("rev_p1_x", seen[1].x, 2); chk("rev_p1_y", seen[1].y, 1);
            chk("rev_p2_x", seen[2].x, 1); chk("rev_p2_y", seen[2].y, 0);
            chk("rev_p3_x", seen[3].x, 0); chk("rev_p3_y", seen[3].y, 0);
        end

        // Single point
        seen.delete();
        send_cmd(7, 9, 7, 9, 2, 1'b0);
        wait_done();
        chk("point_count", seen.size(), 1);
        if (seen.size() == 1) chk("point_last", seen[0].last, 1);

        // Steep line with backpressure
        rand_ready = 1'b1;
        seen.delete();
        send_cmd(3, 20, 5, 12, 4, 1'b0);
        wait_done();
        chk("steep_count", seen.size(), 9);
        foreach (seen[i]) chk("steep_y", seen[i].y, 20 - i);
        rand_ready = 1'b0;

        // Full extent
        send_cmd(255, 127, 0, 0, 7, 1'b0);
        wait_done();

        // Command while drawing is ignored
        send_cmd(0, 0, 15, 6, 1, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_x0 = 8'd1;
        bus.cmd_y0 = 7'd1;
        bus.cmd_x1 = 8'd2;
        bus.cmd_y1 = 7'd2;
        @(negedge clk);
        chk("busy_cmd_ready", bus.cmd_ready, 0);
        chk("busy_flag", bus.busy, 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_done();

        // Reset mid-line at the 4th pixel
        seen.delete();
        send_cmd(0, 0, 20, 0, 2, 1'b0);
        n = 0;
        while (seen.size() < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_line_reach_px4", seen.size(), 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_px_valid", bus.px_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_px_x", bus.px_x, 0);
        chk("midrst_cmd_ready", bus.cmd_ready, 0);
        sb.delete();
        exp_count.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_release_cmd_ready", bus.cmd_ready, 1);
        repeat (5) @(negedge clk);
        chk("midrst_no_more_pixels", seen.size(), 3);

        // Random lines, random backpressure
        for (int t = 0; t < 20; t++) begin
            rand_ready = 1'($urandom_range(0, 1));
            send_cmd($urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(0, 7), 1'b0);
            wait_done();
        end
        rand_ready = 1'b0;
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
